// File: rtl/my_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : my_imem_loader
// Description : Boot-time instruction memory loader. Consumes a byte stream
//               made of a 4-byte little-endian word count N followed by N
//               little-endian 32-bit words, and writes each assembled word to
//               the IMEM write port at consecutive word addresses starting at
//               BASE_ADDR. Holds the core PC stalled until the image has been
//               fully written (or forever if the count is out of range).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH_WORDS : IMEM capacity in 32-bit words; legal counts are 0..DEPTH_WORDS
//   BASE_ADDR   : byte address of the first word written (4-byte aligned)
// Ports
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : stream source presents a byte
//   in_data     : stream byte
//   in_ready    : loader accepts a byte this cycle
//   imem_we     : one-cycle IMEM write strobe per word
//   imem_waddr  : IMEM byte address (valid while imem_we=1)
//   imem_wdata  : IMEM write data   (valid while imem_we=1)
//   core_stall  : PC register stall; high while loading or after an error
//   load_done   : image fully written, sticky until reset
//   load_err    : word count exceeded DEPTH_WORDS, sticky until reset
// ============================================================================
module my_imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_stall,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [2:0] S_LEN   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  logic [2:0]  state;
  logic [2:0]  state_next;

  logic [1:0]  byte_idx;     // byte position within the current 4-byte group
  logic [23:0] count_sr;     // first three count bytes, newest in the top byte
  logic [31:0] count;        // latched word count N
  logic [23:0] word_sr;      // first three data bytes, newest in the top byte
  logic [31:0] word_idx;     // index of the word currently being assembled

  logic        accept;
  logic        last_byte;
  logic [31:0] count_full;
  logic [31:0] word_full;
  logic        last_word;

  // A transfer needs both sides; in_ready is only high in LEN and DATA.
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_idx == 2'd3);

  // The fourth byte completes the little-endian value combinationally so the
  // decision and the write can both be made on the edge that accepts it.
  assign count_full = {in_data, count_sr};
  assign word_full  = {in_data, word_sr};

  // Only evaluated in DATA, where count >= 1, so count - 1 never underflows.
  assign last_word  = (word_idx == (count - 32'd1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LEN;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_LEN: begin
        if (last_byte) begin
          if (count_full == 32'd0) begin
            state_next = S_DONE;
          end else if (count_full > DEPTH_LIMIT) begin
            state_next = S_ERR;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_byte && last_word) begin
          state_next = S_FLUSH;
        end
      end
      // FLUSH spans the cycle in which the final write pulse is on the port.
      S_FLUSH: state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_LEN;
    endcase
  end

  // --------------------------------------------------------------------------
  // State-decoded outputs. Being decoded from the state register alone, they
  // take their reset values as soon as rst_n falls.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready   = 1'b0;
    core_stall = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state)
      S_LEN:   in_ready = 1'b1;
      S_DATA:  in_ready = 1'b1;
      S_FLUSH: in_ready = 1'b0;
      S_DONE: begin
        core_stall = 1'b0;
        load_done  = 1'b1;
      end
      S_ERR:   load_err = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Byte assembly and IMEM write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= 2'd0;
      count_sr   <= 24'd0;
      count      <= 32'd0;
      word_sr    <= 24'd0;
      word_idx   <= 32'd0;
      imem_we    <= 1'b0;
      imem_waddr <= 32'd0;
      imem_wdata <= 32'd0;
    end else begin
      // Strobe is a single-cycle pulse; address and data hold between pulses.
      imem_we <= 1'b0;

      if (accept) begin
        // Wraps 3 -> 0, so the LEN -> DATA hand-off starts at byte 0.
        byte_idx <= byte_idx + 2'd1;

        if (state == S_LEN) begin
          count_sr <= count_full[31:8];
          word_idx <= 32'd0;
          if (byte_idx == 2'd3) begin
            count <= count_full;
          end
        end

        if (state == S_DATA) begin
          word_sr <= word_full[31:8];
          if (byte_idx == 2'd3) begin
            imem_we    <= 1'b1;
            imem_waddr <= BASE_ADDR + (word_idx << 2);
            imem_wdata <= word_full;
            word_idx   <= word_idx + 32'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_my_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_my_imem_loader
// Description : Directed self-checking bench for my_imem_loader. Instance
//               "dut" uses BASE_ADDR=0; instance "dut_hi" uses
//               BASE_ADDR=0x8000_0000 for the full-depth image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_my_imem_loader;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  // dut (BASE_ADDR = 0)
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_stall;
  logic        load_done;
  logic        load_err;

  // dut_hi (BASE_ADDR = 0x8000_0000)
  logic        rst_n_h;
  logic        in_valid_h;
  logic [7:0]  in_data_h;
  logic        in_ready_h;
  logic        imem_we_h;
  logic [31:0] imem_waddr_h;
  logic [31:0] imem_wdata_h;
  logic        core_stall_h;
  logic        load_done_h;
  logic        load_err_h;

  my_imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_stall (core_stall),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  my_imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h8000_0000)) dut_hi (
    .clk        (clk),
    .rst_n      (rst_n_h),
    .in_valid   (in_valid_h),
    .in_data    (in_data_h),
    .in_ready   (in_ready_h),
    .imem_we    (imem_we_h),
    .imem_waddr (imem_waddr_h),
    .imem_wdata (imem_wdata_h),
    .core_stall (core_stall_h),
    .load_done  (load_done_h),
    .load_err   (load_err_h)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write recorder for dut: address, data, cycle and accepted-byte count at
  // each pulse. acc is stepped by the driver on the accepting edge.
  int          acc = 0;
  logic [31:0] wa   [16];
  logic [31:0] wd   [16];
  int          wc   [16];
  int          wacc [16];
  int          nwr = 0;

  always @(negedge clk) begin
    if (imem_we) begin
      if (nwr < 16) begin
        wa[nwr]   <= imem_waddr;
        wd[nwr]   <= imem_wdata;
        wc[nwr]   <= cyc;
        wacc[nwr] <= acc;
      end
      nwr <= nwr + 1;
    end
  end

  // Recorder for dut_hi: word k must land at 0x8000_0000+4k with 0xA500_0000|k.
  int          nwr_h = 0;
  int          bad_h = 0;
  logic [31:0] last_a_h = 32'd0;
  logic [31:0] last_d_h = 32'd0;

  always @(negedge clk) begin
    if (imem_we_h) begin
      if ((imem_waddr_h !== (32'h8000_0000 + 32'(nwr_h) * 32'd4)) ||
          (imem_wdata_h !== (32'hA500_0000 | 32'(nwr_h))))
        bad_h <= bad_h + 1;
      last_a_h <= imem_waddr_h;
      last_d_h <= imem_wdata_h;
      nwr_h    <= nwr_h + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},   64'(in_ready),   64'd1);
    chk({tag, "_imem_we"},    64'(imem_we),    64'd0);
    chk({tag, "_imem_waddr"}, 64'(imem_waddr), 64'd0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_core_stall"}, 64'(core_stall), 64'd1);
    chk({tag, "_load_done"},  64'(load_done),  64'd0);
    chk({tag, "_load_err"},   64'(load_err),   64'd0);
  endtask

  // Present one byte for one edge; took reports whether it was accepted.
  task automatic offer(input bit h, input logic [7:0] b, output bit took);
    if (h) begin
      in_valid_h = 1'b1;
      in_data_h  = b;
      took       = in_ready_h;
    end else begin
      in_valid = 1'b1;
      in_data  = b;
      took     = in_ready;
    end
    @(posedge clk);
    if (took && !h) acc = acc + 1;
    @(negedge clk);
    if (h) in_valid_h = 1'b0;
    else   in_valid   = 1'b0;
  endtask

  task automatic send(input bit h, input logic [7:0] b);
    bit took;
    int tries;
    took  = 1'b0;
    tries = 0;
    while (!took && tries < 40) begin
      offer(h, b, took);
      tries = tries + 1;
    end
    if (!took) chk("byte_accept_timeout", 64'(took), 64'd1);
  endtask

  task automatic send_word(input bit h, input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(h, w[8*k +: 8]);
    end
  endtask

  task automatic wait_done(input bit h, output int c);
    int t;
    t = 0;
    while (!(h ? load_done_h : load_done) && t < 40) begin
      @(negedge clk);
      t = t + 1;
    end
    c = cyc;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc   = 0;
    @(negedge clk);
  endtask

  logic [31:0] img [3];
  int          base;
  int          dc;
  bit          took;

  initial begin
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    img[2] = 32'hFFF0_0113;

    rst_n = 1'b0;  in_valid = 1'b0;  in_data = 8'd0;
    rst_n_h = 1'b0; in_valid_h = 1'b0; in_data_h = 8'd0;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    rst_n_h = 1'b1;
    @(negedge clk);

    // ---- N=3 back-to-back ----
    base = nwr;
    send_word(1'b0, 32'd3, 1'b0);
    for (int i = 0; i < 3; i++) send_word(1'b0, img[i], 1'b0);
    wait_done(1'b0, dc);
    chk("b2b_nwrites", 64'(nwr - base), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_addr%0d", i), 64'(wa[base+i]), 64'(32'(i) * 32'd4));
      chk($sformatf("b2b_data%0d", i), 64'(wd[base+i]), 64'(img[i]));
    end
    chk("b2b_gap01", 64'(wc[base+1] - wc[base]), 64'd4);
    chk("b2b_gap12", 64'(wc[base+2] - wc[base+1]), 64'd4);
    chk("b2b_done_latency", 64'(dc - wc[base+2]), 64'd1);
    chk("b2b_core_stall", 64'(core_stall), 64'd0);
    chk("b2b_in_ready", 64'(in_ready), 64'd0);
    chk("b2b_load_err", 64'(load_err), 64'd0);

    // ---- same image with random in_valid gaps ----
    do_reset();
    base = nwr;
    send_word(1'b0, 32'd3, 1'b1);
    for (int i = 0; i < 3; i++) send_word(1'b0, img[i], 1'b1);
    wait_done(1'b0, dc);
    chk("gap_nwrites", 64'(nwr - base), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("gap_addr%0d", i), 64'(wa[base+i]), 64'(32'(i) * 32'd4));
      chk($sformatf("gap_data%0d", i), 64'(wd[base+i]), 64'(img[i]));
      chk($sformatf("gap_bytes_before%0d", i), 64'(wacc[base+i]), 64'(8 + 4 * i));
    end
    chk("gap_load_done", 64'(load_done), 64'd1);

    // ---- N=0 ----
    do_reset();
    base = nwr;
    send_word(1'b0, 32'd0, 1'b0);
    chk("n0_load_done", 64'(load_done), 64'd1);
    chk("n0_core_stall", 64'(core_stall), 64'd0);
    chk("n0_in_ready", 64'(in_ready), 64'd0);
    offer(1'b0, 8'h55, took);
    chk("n0_byte_refused", 64'(took), 64'd0);
    chk("n0_no_write", 64'(nwr - base), 64'd0);

    // ---- N=257 -> error ----
    do_reset();
    base = nwr;
    send_word(1'b0, 32'd257, 1'b0);
    chk("err_load_err", 64'(load_err), 64'd1);
    chk("err_core_stall", 64'(core_stall), 64'd1);
    chk("err_in_ready", 64'(in_ready), 64'd0);
    chk("err_load_done", 64'(load_done), 64'd0);
    offer(1'b0, 8'hAA, took);
    chk("err_byte_refused", 64'(took), 64'd0);
    repeat (3) @(negedge clk);
    chk("err_no_write", 64'(nwr - base), 64'd0);
    chk("err_sticky", 64'(load_err), 64'd1);

    // ---- BASE_ADDR=0x8000_0000, N=DEPTH_WORDS ----
    send_word(1'b1, 32'd256, 1'b0);
    for (int i = 0; i < 256; i++) send_word(1'b1, 32'hA500_0000 | 32'(i), 1'b0);
    offer(1'b1, 8'h77, took);
    chk("full_byte_after_refused", 64'(took), 64'd0);
    wait_done(1'b1, dc);
    chk("full_nwrites", 64'(nwr_h), 64'd256);
    chk("full_bad_writes", 64'(bad_h), 64'd0);
    chk("full_last_addr", 64'(last_a_h), 64'h8000_03FC);
    chk("full_last_data", 64'(last_d_h), 64'hA500_00FF);
    chk("full_load_done", 64'(load_done_h), 64'd1);
    chk("full_load_err", 64'(load_err_h), 64'd0);
    chk("full_core_stall", 64'(core_stall_h), 64'd0);

    // ---- reset mid-load after word 1 byte 2 ----
    do_reset();
    base = nwr;
    send_word(1'b0, 32'd2, 1'b0);
    send_word(1'b0, 32'hDEAD_BEEF, 1'b0);
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    send(1'b0, 8'h33);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    chk("midrst_word0_written", 64'(nwr - base), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    acc   = 0;
    @(negedge clk);
    base = nwr;
    send_word(1'b0, 32'd1, 1'b0);
    send_word(1'b0, 32'h1234_5678, 1'b0);
    wait_done(1'b0, dc);
    chk("fresh_nwrites", 64'(nwr - base), 64'd1);
    chk("fresh_addr", 64'(wa[base]), 64'd0);
    chk("fresh_data", 64'(wd[base]), 64'h1234_5678);
    chk("fresh_load_done", 64'(load_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
